// File: rtl/decode_stage_if.sv
// Bundle of signals between fetch, decode, execute and write-back as seen by the decode stage.
// The master side drives the fetch latch and pipeline feedback; the slave side is the decode stage.
interface decode_stage_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_npc;
    logic        wb_wen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        ex_stall;
    logic        flush;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_npc;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rdat1;
    logic [31:0] id_rdat2;
    logic [31:0] id_imm;
    logic        id_halt;
    logic        halted;

    modport master (
        output if_valid, if_instr, if_npc, wb_wen, wb_wsel, wb_wdat,
               ex_memread, ex_rt, ex_stall, flush,
        input  stall, id_valid, id_npc, id_opcode, id_funct, id_shamt,
               id_rs, id_rt, id_rd, id_rdat1, id_rdat2, id_imm, id_halt, halted
    );

    modport slave (
        input  if_valid, if_instr, if_npc, wb_wen, wb_wsel, wb_wdat,
               ex_memread, ex_rt, ex_stall, flush,
        output stall, id_valid, id_npc, id_opcode, id_funct, id_shamt,
               id_rs, id_rt, id_rd, id_rdat1, id_rdat2, id_imm, id_halt, halted
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: register file with write-back bypass, load-use hazard detection,
// halt tracking and the registered decode latch handed to execute.
module decode_stage #(
    parameter logic [5:0] HALT_OP = 6'h3F,
    parameter int          NREGS   = 32
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);

    typedef struct packed {
        logic        valid;
        logic [31:0] npc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic        halt;
    } idLatchT;

    logic [31:0] regs [NREGS];
    idLatchT     idLatch;
    idLatchT     decoded;
    logic        haltedReg;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        usesRt;
    logic        hazard;

    assign opcode = bus.if_instr[31:26];
    assign rs     = bus.if_instr[25:21];
    assign rt     = bus.if_instr[20:16];

    // Register 0 is never written, so after reset it reads zero without a special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_wen && bus.wb_wsel != 5'd0) begin
            regs[bus.wb_wsel] <= bus.wb_wdat;
        end
    end

    always_comb begin
        decoded        = '0;
        decoded.valid  = bus.if_valid;
        decoded.npc    = bus.if_npc;
        decoded.opcode = opcode;
        decoded.funct  = bus.if_instr[5:0];
        decoded.shamt  = bus.if_instr[10:6];
        decoded.rs     = rs;
        decoded.rt     = rt;
        decoded.rd     = bus.if_instr[15:11];
        decoded.halt   = bus.if_valid && (opcode == HALT_OP);
        decoded.rdat1  = (bus.wb_wen && bus.wb_wsel == rs && rs != 5'd0) ? bus.wb_wdat : regs[rs];
        decoded.rdat2  = (bus.wb_wen && bus.wb_wsel == rt && rt != 5'd0) ? bus.wb_wdat : regs[rt];
        case (opcode)
            6'h0C, 6'h0D, 6'h0E: decoded.imm = {16'h0000, bus.if_instr[15:0]};
            6'h0F:               decoded.imm = {bus.if_instr[15:0], 16'h0000};
            default:             decoded.imm = {{16{bus.if_instr[15]}}, bus.if_instr[15:0]};
        endcase
    end

    // Only R-type, branches and stores actually read rt as a source operand.
    assign usesRt = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h05) || (opcode == 6'h2B);
    assign hazard = bus.if_valid && bus.ex_memread && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == rs) || (usesRt && bus.ex_rt == rt));
    assign bus.stall = hazard || bus.ex_stall || haltedReg;

    // Flush must win over ex_stall so a squashed instruction never survives a held latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            idLatch   <= '0;
            haltedReg <= 1'b0;
        end else if (bus.flush) begin
            idLatch <= '0;
        end else if (bus.ex_stall) begin
            idLatch <= idLatch;
        end else if (haltedReg || hazard) begin
            idLatch <= '0;
        end else begin
            idLatch <= decoded;
            if (decoded.halt) begin
                haltedReg <= 1'b1;
            end
        end
    end

    assign bus.id_valid  = idLatch.valid;
    assign bus.id_npc    = idLatch.npc;
    assign bus.id_opcode = idLatch.opcode;
    assign bus.id_funct  = idLatch.funct;
    assign bus.id_shamt  = idLatch.shamt;
    assign bus.id_rs     = idLatch.rs;
    assign bus.id_rt     = idLatch.rt;
    assign bus.id_rd     = idLatch.rd;
    assign bus.id_rdat1  = idLatch.rdat1;
    assign bus.id_rdat2  = idLatch.rdat2;
    assign bus.id_imm    = idLatch.imm;
    assign bus.id_halt   = idLatch.halt;
    assign bus.halted    = haltedReg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a behavioural model predicts each cycle's latch contents,
// a monitor compares them after every rising edge; stall is checked just before the edge.
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] npc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic        halt;
        logic        halted;
    } expT;

    logic clk;
    logic rst;
    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          testsRun  = 0;
    int          failCount = 0;
    expT         expQ[$];
    logic [31:0] mRegs [32];
    expT         mLatch;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the register file is updated first, so a read naturally sees a same-cycle write-back.
    task automatic applyStimulus(input logic rstV, input logic valid, input logic [31:0] instr,
                                 input logic [31:0] npc, input logic wen, input logic [4:0] wsel,
                                 input logic [31:0] wdat, input logic memread, input logic [4:0] exRt,
                                 input logic exStall, input logic flushV);
        logic [31:0] newRegs [32];
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        readsRt;
        logic        hz;
        expT         dec;
        @(negedge clk);
        rst            = rstV;
        bus.if_valid   = valid;
        bus.if_instr   = instr;
        bus.if_npc     = npc;
        bus.wb_wen     = wen;
        bus.wb_wsel    = wsel;
        bus.wb_wdat    = wdat;
        bus.ex_memread = memread;
        bus.ex_rt      = exRt;
        bus.ex_stall   = exStall;
        bus.flush      = flushV;
        op      = instr[31:26];
        rs      = instr[25:21];
        rt      = instr[20:16];
        readsRt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        hz      = valid && memread && exRt != 0 && (exRt == rs || (readsRt && exRt == rt));
        #4;
        if (!rstV) checkOutput("stall", {31'd0, bus.stall}, {31'd0, hz || exStall || mLatch.halted});
        if (rstV) begin
            for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
            mLatch = '0;
        end else begin
            for (int i = 0; i < 32; i++) newRegs[i] = mRegs[i];
            if (wen) newRegs[wsel] = wdat;
            newRegs[0] = 32'd0;
            dec        = '0;
            dec.valid  = valid;
            dec.npc    = npc;
            dec.opcode = op;
            dec.funct  = instr[5:0];
            dec.shamt  = instr[10:6];
            dec.rs     = rs;
            dec.rt     = rt;
            dec.rd     = instr[15:11];
            dec.rdat1  = newRegs[rs];
            dec.rdat2  = newRegs[rt];
            if (op >= 6'h0C && op <= 6'h0E) dec.imm = 32'(instr[15:0]);
            else if (op == 6'h0F)           dec.imm = 32'(instr[15:0]) << 16;
            else                            dec.imm = 32'($signed(instr[15:0]));
            dec.halt   = valid && op == 6'h3F;
            dec.halted = mLatch.halted || dec.halt;
            if (flushV)                    mLatch = '{halted: mLatch.halted, default: '0};
            else if (exStall)              mLatch = mLatch;
            else if (mLatch.halted || hz)  mLatch = '{halted: mLatch.halted, default: '0};
            else                           mLatch = dec;
            for (int i = 0; i < 32; i++) mRegs[i] = newRegs[i];
        end
        expQ.push_back(mLatch);
    endtask

    task automatic idle(input logic valid, input logic [31:0] instr);
        applyStimulus(0, valid, instr, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("id_valid", {31'd0, bus.id_valid}, {31'd0, e.valid});
                checkOutput("id_npc", bus.id_npc, e.npc);
                checkOutput("id_opcode", {26'd0, bus.id_opcode}, {26'd0, e.opcode});
                checkOutput("id_funct", {26'd0, bus.id_funct}, {26'd0, e.funct});
                checkOutput("id_shamt", {27'd0, bus.id_shamt}, {27'd0, e.shamt});
                checkOutput("id_rs", {27'd0, bus.id_rs}, {27'd0, e.rs});
                checkOutput("id_rt", {27'd0, bus.id_rt}, {27'd0, e.rt});
                checkOutput("id_rd", {27'd0, bus.id_rd}, {27'd0, e.rd});
                checkOutput("id_rdat1", bus.id_rdat1, e.rdat1);
                checkOutput("id_rdat2", bus.id_rdat2, e.rdat2);
                checkOutput("id_imm", bus.id_imm, e.imm);
                checkOutput("id_halt", {31'd0, bus.id_halt}, {31'd0, e.halt});
                checkOutput("halted", {31'd0, bus.halted}, {31'd0, e.halted});
            end
        end
    end

    initial begin : stimulus
        logic [5:0]  opList [10];
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  exRt;
        logic [31:0] instr;
        opList = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};
        mLatch = '0;
        for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;

        // A write-back during reset must be dropped.
        applyStimulus(1, 1, rtype(3, 3, 1), 32'h4, 1, 3, 32'hAAAA_AAAA, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'd0, 32'h8, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        idle(1, rtype(5, 0, 1));
        idle(1, rtype(3, 0, 1));
        applyStimulus(0, 1, rtype(8, 0, 2), 32'hC, 1, 8, 32'h0000_1234, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'd0, 32'h10, 1, 0, 32'h0000_FFFF, 0, 0, 0, 0);
        idle(1, rtype(0, 0, 3));
        // Load-use hazard, then the same instruction once the load has moved on.
        applyStimulus(0, 1, rtype(9, 0, 4), 32'h14, 0, 0, 0, 1, 9, 0, 0);
        applyStimulus(0, 1, rtype(9, 0, 4), 32'h14, 0, 0, 0, 0, 9, 0, 0);
        applyStimulus(0, 1, itype(6'h08, 3, 9, 16'h0001), 32'h18, 0, 0, 0, 1, 9, 0, 0);
        applyStimulus(0, 1, rtype(1, 9, 4), 32'h1C, 0, 0, 0, 1, 9, 0, 0);
        idle(1, itype(6'h0D, 1, 2, 16'h8001));
        idle(1, itype(6'h08, 1, 2, 16'h8001));
        idle(1, itype(6'h0F, 0, 2, 16'h8001));
        idle(1, rtype(5, 8, 6));
        applyStimulus(0, 1, rtype(1, 2, 3), 32'h20, 0, 0, 0, 0, 0, 1, 1);
        idle(1, rtype(8, 5, 7));
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, rtype(2, 3, 4), 32'h24, 0, 0, 0, 0, 0, 1, 0);

        for (int n = 0; n < 400; n++) begin
            op    = opList[$urandom_range(9)];
            rs    = 5'($urandom_range(7));
            instr = {op, rs, 5'($urandom_range(7)), 16'($urandom)};
            exRt  = ($urandom_range(1) == 1) ? rs : 5'($urandom_range(7));
            applyStimulus($urandom_range(49) == 0, $urandom_range(7) != 0, instr, $urandom,
                          $urandom_range(1) == 1, 5'($urandom_range(7)), $urandom,
                          $urandom_range(2) == 0, exRt, $urandom_range(5) == 0, $urandom_range(9) == 0);
        end

        // HALT sticks until reset; later valid instructions become bubbles.
        idle(1, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) idle(1, rtype(1, 2, 3));
        applyStimulus(1, 1, rtype(1, 2, 3), 32'h30, 0, 0, 0, 0, 0, 0, 0);
        idle(1, rtype(1, 2, 3));

        @(negedge clk);
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
